// File: rtl/mmio_uart_tx_pkg.sv
// mmio_pkg: register offsets, STATUS bit positions and TX FSM states for mmio_uart_tx.
package mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_OVFCNT = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers; pushes to a full FIFO are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_q] <= din;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on the single-cycle MIPS data bus.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     idx_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic [7:0]     ovf_q, ovf_d;

    logic [1:0]     off;
    logic           wr_en, push, pop, bit_last;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [AW:0]    fifo_count;
    logic [31:0]    status;
    logic           unused_bits;

    assign unused_bits = ^{dataadr[1:0], writedata[31:8]};

    assign hit      = dataadr[31:4] == BASE_ADDR[31:4];
    assign off      = dataadr[3:2];
    assign wr_en    = memwrite && hit;
    assign push     = wr_en && off == OFF_TXDATA;
    assign bit_last = cnt_q == CNT_LAST;
    // Pop at IDLE, or on the last stop-bit cycle so the next frame follows without a gap.
    assign pop      = !fifo_empty && (state_q == IDLE || (state_q == STOP && bit_last));
    assign tx       = tx_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (writedata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = state_q != IDLE;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_CNT_LSB +: 8]    = 8'(fifo_count);
        readdata = !hit                ? 32'd0 :
                   off == OFF_STATUS   ? status :
                   off == OFF_OVFCNT   ? {24'd0, ovf_q} : 32'd0;
    end

    always_comb begin
        ovf_d = (wr_en && off == OFF_OVFCNT)              ? 8'd0 :
                (push && fifo_full && ovf_q != 8'hFF)     ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= START;
                        shift_q <= fifo_dout;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        if (!fifo_empty) begin
                            state_q <= START;
                            shift_q <= fifo_dout;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: random + directed bus traffic against a timeline model of accepted bytes; a tx-line monitor scores frames.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0, reset = 1'b1, memwrite = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;
    logic [31:0] readdata;
    logic        hit, tx;

    int total = 0, bad = 0, cyc = 0;
    int m_push[$], m_pop[$];
    int exp_byte[$], exp_start[$];
    int last_pop = -1000, ovf_m = 0;
    int mon_start = -1;
    logic [7:0] mon_byte = '0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .hit(hit), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bytes in the FIFO after edge n: pushed at or before n, not yet popped.
    function automatic int fifo_cnt(int n);
        int c = 0;
        foreach (m_pop[i]) if (m_push[i] <= n && m_pop[i] > n) c++;
        return c;
    endfunction

    function automatic logic busy_at(int n);
        foreach (m_pop[i]) if (m_pop[i] <= n && n < m_pop[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rd_exp(logic [31:0] a, int n);
        int c;
        if (a[31:4] != BASE[31:4]) return 32'd0;
        c = fifo_cnt(n);
        if (a[3:2] == 2'd1) return {16'd0, c[7:0], 5'd0, c == 0, c == DEPTH, busy_at(n)};
        if (a[3:2] == 2'd2) return ovf_m;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_push.delete(); m_pop.delete(); exp_byte.delete(); exp_start.delete();
        last_pop = -1000;
        ovf_m = 0;
    endtask

    // A byte written at edge k starts transmitting at the later of k+1 and the end of the previous frame.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int k, c, p;
        @(posedge clk); #1;
        memwrite = 1'b1; dataadr = a; writedata = d;
        k = cyc + 1;
        if (a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd0) begin
                c = 0;
                foreach (m_pop[i]) if (m_pop[i] >= k) c++;
                if (c == DEPTH) ovf_m = (ovf_m == 255) ? 255 : ovf_m + 1;
                else begin
                    p = (k + 1 > last_pop + FRAME) ? k + 1 : last_pop + FRAME;
                    last_pop = p;
                    m_push.push_back(k); m_pop.push_back(p);
                    exp_byte.push_back(int'(d[7:0])); exp_start.push_back(p);
                end
            end else if (a[3:2] == 2'd2) ovf_m = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            memwrite = 1'b0;
        end
    endtask

    task automatic rd(input logic [31:0] a, input string name);
        @(posedge clk); #1;
        memwrite = 1'b0; dataadr = a;
        #1;
        chk(name, readdata, rd_exp(a, cyc));
        chk({name, "_hit"}, {31'd0, hit}, {31'd0, a[31:4] == BASE[31:4]});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; memwrite = 1'b1; dataadr = BASE; writedata = 32'h77;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0; memwrite = 1'b0;
        chk("tx_after_reset", {31'd0, tx}, 32'd1);
    endtask

    // Frame monitor: first low after idle is a start bit; bits sampled mid-period.
    always @(negedge clk) begin
        int d;
        d = cyc - mon_start;
        if (reset) mon_start = -1;
        else if (mon_start < 0) begin
            if (tx !== 1'b1) begin
                mon_start = cyc;
                if (exp_start.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: tx low at cycle %0d, expected idle", cyc);
                end else chk("start_time", cyc, exp_start[0]);
            end
        end else begin
            if (d == 2) chk("start_bit", {31'd0, tx}, 32'd0);
            if (d >= 6 && d <= 34 && (d - 6) % CPB == 0) mon_byte[(d - 6) / CPB] = tx;
            if (d == 38) begin
                chk("stop_bit", {31'd0, tx}, 32'd1);
                if (exp_byte.size() != 0) begin
                    chk("frame_byte", {24'd0, mon_byte}, exp_byte[0]);
                    void'(exp_byte.pop_front());
                    void'(exp_start.pop_front());
                end
                mon_start = -1;
            end
        end
    end

    initial begin
        int r, guard;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk("tx_idle_reset", {31'd0, tx}, 32'd1);
        rd(BASE + 4, "status_reset");
        chk("status_reset_const", readdata, 32'h0000_0004);
        rd(32'h0000_1000, "miss_read");
        chk("miss_read_const", readdata, 32'd0);

        wr(BASE, 32'h55);
        repeat (12) begin idle(2); rd(BASE + 4, "status_frame"); end
        idle(20);
        rd(BASE + 4, "status_after_55");
        chk("status_after_55_const", readdata, 32'h0000_0004);

        wr(BASE, 32'h01); wr(BASE, 32'h02);
        idle(85);
        rd(BASE + 4, "status_after_pair");

        for (int i = 0; i < 6; i++) wr(BASE, 32'h10 + i);
        rd(BASE + 8, "ovf_one");
        chk("ovf_one_const", readdata, 32'd1);
        rd(BASE + 4, "status_full");
        chk("status_full_const", readdata, 32'h0000_0403);
        wr(BASE + 8, 32'hFFFF_FFFF);
        rd(BASE + 8, "ovf_cleared");
        chk("ovf_cleared_const", readdata, 32'd0);
        idle(5 * FRAME);

        wr(BASE, 32'hA5); wr(BASE, 32'h3C); wr(BASE, 32'hC3);
        idle(15);
        do_reset();
        rd(BASE + 4, "status_post_reset");
        chk("status_post_reset_const", readdata, 32'h0000_0004);
        rd(BASE + 8, "ovf_post_reset");
        idle(60);

        wr(BASE + 4, 32'h12); wr(BASE + 12, 32'h34); wr(32'h0, 32'h56);
        idle(3);
        rd(BASE + 4, "status_ignored_writes");
        chk("status_ignored_const", readdata, 32'h0000_0004);
        chk("tx_ignored_writes", {31'd0, tx}, 32'd1);
        idle(50);

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) wr(BASE, $urandom);
            else if (r < 60) rd(BASE + 4, "rnd_status");
            else if (r < 70) rd(BASE + 8, "rnd_ovf");
            else if (r < 82) idle($urandom_range(1, 30));
            else if (r < 86) wr(BASE + 8, $urandom);
            else if (r < 98) begin
                a = ($urandom_range(0, 1) == 1) ? BASE + {28'd0, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))} : $urandom;
                wr(a, $urandom);
            end else do_reset();
        end

        guard = 0;
        while ((exp_byte.size() != 0 || mon_start >= 0) && guard < 5000) begin
            idle(1);
            guard++;
        end
        chk("drain_remaining", exp_byte.size(), 0);
        idle(5);
        rd(BASE + 4, "status_final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter acting as a responder on the single-cycle MIPS data bus (memwrite/dataadr/writedata/readdata).
- It claims a 16-byte address window. The top level routes readdata from this block when hit=1 and from dmem otherwise, and gates dmem's write enable with !hit.
- The CPU pushes bytes into an internal FIFO. A bit-timing FSM serialises them as 8N1 frames on tx.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: window base. Bits [3:0] must be 0.
- CLKS_PER_BIT, 16: clk cycles per serial bit. Minimum 2.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- memwrite  in  1  bus write strobe, sampled at rising edge
- dataadr  in  32  bus byte address
- writedata  in  32  bus write data
- readdata  out  32  combinational read data. 0 when hit=0.
- hit  out  1  combinational: dataadr[31:4] == BASE_ADDR[31:4]
- tx  out  1  serial output, idle high

Behaviour:
- Register map, offset = dataadr[3:2]; dataadr[1:0] ignored:
  - 0 TXDATA. A write pushes writedata[7:0]. Reads return 0.
  - 1 STATUS, read-only. bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bits[15:8] FIFO count. Other bits 0.
  - 2 OVFCNT. Reads return {24'b0, ovf}. Any write clears ovf to 0.
  - 3 reserved. Reads return 0, writes are ignored.
- Reads are combinational, with zero latency, so the single-cycle CPU sees data in the same cycle.
- Writes take effect at the rising edge where memwrite=1 and hit=1. With hit=0 the block has no effect.
- FIFO:
  - Push to TXDATA when count==FIFO_DEPTH: the byte is dropped, and ovf increments, saturating at 255.
  - Full is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs on that edge.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. A bit counter spans 0..CLKS_PER_BIT-1 and an index spans 0..7.
  - IDLE: tx=1. When FIFO is non-empty, pop the head into a shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, go to START with a new pop if FIFO is non-empty (no idle gap), otherwise go to IDLE.
- tx is registered.
- Latency: a push at edge k into an empty FIFO with FSM in IDLE gives tx=0 after edge k+1. A frame occupies exactly 10*CLKS_PER_BIT cycles.
- Reset, including mid-frame: FIFO empty, ovf=0, FSM IDLE, counters 0, tx=1 after the reset edge. A frame in progress is aborted with no further bits.
- Writes during reset are ignored.
- readdata and hit are combinational and not reset-dependent. After reset, STATUS reads 32'h0000_0004.

Decomposition:
- Package mmio_pkg holds:
  - offset constants: OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_OVFCNT=2'd2
  - STATUS bit index constants
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP}
- One sub-module: sync_fifo (params WIDTH=8, DEPTH; ports clk, reset, push, din, pop, dout, full, empty, count). Pointers wrap modulo DEPTH.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then read 0xFFFF0004 -> readdata=0x00000004, hit=1, tx=1. Read 0x00001000 -> hit=0, readdata=0.
- Write 0x55 to 0xFFFF0000 at edge k -> tx=0 for cycles k+1..k+4, then data bits 1,0,1,0,1,0,1,0 each 4 cycles, then stop=1. STATUS busy=1 during the frame and returns to 0x00000004 after 40 cycles.
- Write 0x01, 0x02 on consecutive cycles -> two frames back-to-back, second start bit immediately after the first stop bit, 80 cycles total.
- Write 6 bytes in 6 consecutive cycles -> the first byte pops at the first IDLE edge, 4 more fill the FIFO, 1 is dropped. OVFCNT reads 1, STATUS count=4, full=1. Writing OVFCNT then reads 0.
- Assert reset for 1 cycle mid-DATA of 0xA5 with 2 bytes queued -> tx=1 after the reset edge, no further frames, STATUS=0x00000004, OVFCNT=0.
- Write to 0xFFFF0004 and 0xFFFF000C, and to 0x00000000 with hit=0 -> no FIFO change, tx stays 1.
